// File: rtl/spram_burst_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// spram_burst_ctrl_pkg
// Shared definitions for the single-port RAM burst controller: FSM state
// encoding, default geometry and the beat-counter width.
// ---------------------------------------------------------------------------
package spram_burst_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DEPTH  = 32;

  // Holds cmd_len + 1, i.e. 1..16 beats.
  localparam int BEAT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage : spram_burst_ctrl_pkg

// File: rtl/spram_burst_ctrl.sv
// ---------------------------------------------------------------------------
// spram_burst_ctrl
// Burst controller in front of a single-port synchronous RAM (1-cycle read
// latency). Accepts write or read bursts of 1..16 beats starting at any
// implemented address; the address wraps modulo DEPTH. Read beats stream at
// one per clock while rd_ready is high and stall losslessly otherwise.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only when idle)
//   cmd_write, cmd_addr, cmd_len  direction, start address, beats-1
//   wr_valid/wr_ready/wr_data  write-beat stream into the RAM
//   rd_valid/rd_ready/rd_data  read-beat stream out of the RAM
//   ram_en, ram_we, ram_addr, ram_data, ram_q  RAM port
//   busy                       FSM not idle
//   done, err                  one-cycle pulses: burst finished / bad address
// ---------------------------------------------------------------------------
module spram_burst_ctrl
  import spram_burst_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;          // next address to write / issue
  logic [ADDR_W-1:0]   ram_addr_q;            // address presented last cycle
  logic [BEAT_W-1:0]   beats_q, beats_d;      // beats still to complete
  logic [BEAT_W-1:0]   iss_q, iss_d;          // read addresses still to issue
  logic                qv_q, qv_d;            // ram_q holds an unloaded beat
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                err_q, err_d;
  logic                load, issue, rd_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      ram_addr_q <= '0;
      beats_q    <= '0;
      iss_q      <= '0;
      qv_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ram_addr_q <= ram_addr;
      beats_q    <= beats_d;
      iss_q      <= iss_d;
      qv_q       <= qv_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    beats_d    = beats_q;
    iss_d      = iss_q;
    qv_d       = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    err_d      = 1'b0;
    load       = 1'b0;
    issue      = 1'b0;
    rd_hs      = rd_valid_q & rd_ready;
    ram_en     = 1'b1;
    ram_we     = 1'b0;
    ram_data   = wr_data;
    ram_addr   = ram_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if ({1'b0, cmd_addr} < DEPTH_EXT) begin
            ptr_d   = cmd_addr;
            beats_d = {1'b0, cmd_len} + BEAT_W'(1);
            iss_d   = {1'b0, cmd_len} + BEAT_W'(1);
            state_d = cmd_write ? ST_WRITE : ST_READ;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        if (wr_valid) begin
          ram_we   = 1'b1;
          ram_addr = ptr_q;
          ptr_d    = wrap_inc(ptr_q);
          beats_d  = beats_q - BEAT_W'(1);
          if (beats_q == BEAT_W'(1)) state_d = ST_DONE;
        end
      end

      ST_READ: begin
        // The output register refills whenever it is empty or being drained.
        // A new address is issued only when ram_q is free or being consumed
        // this cycle; otherwise ram_addr is held so the RAM keeps returning
        // the pending word and no beat is lost during a stall.
        load  = qv_q & (~rd_valid_q | rd_ready);
        issue = (iss_q != '0) & (~qv_q | load);
        if (issue) begin
          ram_addr = ptr_q;
          ptr_d    = wrap_inc(ptr_q);
          iss_d    = iss_q - BEAT_W'(1);
        end
        qv_d       = issue | (qv_q & ~load);
        if (load) rd_data_d = ram_q;
        rd_valid_d = load | (rd_valid_q & ~rd_ready);
        if (rd_hs) begin
          beats_d = beats_q - BEAT_W'(1);
          if (beats_q == BEAT_W'(1)) state_d = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign wr_ready  = (state_q == ST_WRITE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule : spram_burst_ctrl

// File: tb/tb_spram_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spram_burst_ctrl
// Self-checking bench: behavioural RAM beside the DUT, a flat reference
// memory updated with modulo-DEPTH addressing, directed and random bursts.
// ---------------------------------------------------------------------------
module tb_spram_burst_ctrl;
  import spram_burst_ctrl_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [3:0]        cmd_len = '0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_q = '0;
  logic              busy;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] ram     [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  logic [DATA_W-1:0] wbuf    [0:15];

  always #5 clk = ~clk;

  spram_burst_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_q(ram_q),
    .busy(busy), .done(done), .err(err)
  );

  // Single-port synchronous RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_data;
      ram_q <= ram[ram_addr];
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (ram_en !== 1'b1) begin
        errors++;
        $display("FAIL ram_en: got %b expected 1", ram_en);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_cmd(input bit wr, input int addr, input int len);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = ADDR_W'(addr);
    cmd_len   = 4'(len);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready: got %b expected 1", cmd_ready);
    end
    @(posedge clk);
  endtask

  task automatic write_burst(input int addr, input int len, input int gap);
    int i = 0;
    int cyc = 0;
    logic [ADDR_W-1:0] exp_a;
    do_cmd(1'b1, addr, len);
    while (i <= len && cyc < 200) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cyc++;
      wr_valid = (gap == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      wr_data  = wbuf[i];
      #1;
      checks++;
      if (wr_ready !== 1'b1 || ram_we !== wr_valid) begin
        errors++;
        $display("FAIL wr_hs: wr_ready=%b ram_we=%b expected 1/%b", wr_ready, ram_we, wr_valid);
      end
      if (wr_valid) begin
        exp_a = ADDR_W'((addr + i) % DEPTH);
        checks++;
        if (ram_addr !== exp_a || ram_data !== wbuf[i]) begin
          errors++;
          $display("FAIL wr_beat %0d: addr %0d data %h expected %0d %h",
                   i, ram_addr, ram_data, exp_a, wbuf[i]);
        end
        ref_mem[(addr + i) % DEPTH] = wbuf[i];
        i++;
      end
    end
    if (i <= len) begin
      checks++;
      errors++;
      $display("FAIL wr_timeout: %0d beats taken expected %0d", i, len + 1);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || wr_ready !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL wr_done: done=%b busy=%b wr_ready=%b ram_we=%b expected 1 1 0 0",
               done, busy, wr_ready, ram_we);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_idle: done=%b busy=%b cmd_ready=%b expected 0 0 1", done, busy, cmd_ready);
    end
  endtask

  // mode 0: rd_ready always high, 1: toggling, 2: random
  task automatic read_burst(input int addr, input int len, input int mode);
    int got = 0;
    int k = 0;
    bit prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic [ADDR_W-1:0] prev_addr = '0;
    do_cmd(1'b0, addr, len);
    while (got <= len && k < 300) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      k++;
      rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 1) : 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (ram_we !== 1'b0) begin
        errors++;
        $display("FAIL rd_we: ram_we=%b expected 0", ram_we);
      end
      if (prev_stall) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== prev_data) begin
          errors++;
          $display("FAIL rd_hold: valid=%b data %h expected 1 %h", rd_valid, rd_data, prev_data);
        end
      end
      if (rd_valid && !rd_ready) begin
        checks++;
        if (ram_addr !== prev_addr) begin
          errors++;
          $display("FAIL stall_addr: got %0d expected %0d", ram_addr, prev_addr);
        end
      end
      if (rd_valid && rd_ready) begin
        checks++;
        if (rd_data !== ref_mem[(addr + got) % DEPTH]) begin
          errors++;
          $display("FAIL rd_beat %0d: got %h expected %h", got, rd_data, ref_mem[(addr + got) % DEPTH]);
        end
        if (mode == 0) begin
          checks++;
          if (k !== 3 + got) begin
            errors++;
            $display("FAIL rd_timing beat %0d: cycle %0d expected %0d", got, k, 3 + got);
          end
        end
        got++;
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      prev_addr  = ram_addr;
    end
    if (got <= len) begin
      checks++;
      errors++;
      $display("FAIL rd_timeout: %0d beats got expected %0d", got, len + 1);
    end
    @(negedge clk);
    rd_ready = 1'b1;
    #1;
    checks++;
    if (done !== 1'b1 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_done: done=%b rd_valid=%b expected 1 0", done, rd_valid);
    end
    @(negedge clk);
    rd_ready = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_idle: busy=%b done=%b rd_valid=%b expected 0 0 0", busy, done, rd_valid);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%b done=%b err=%b expected 0 0 0", busy, done, err);
    end
    checks++;
    if (rd_valid !== 1'b0 || wr_ready !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: rd_valid=%b wr_ready=%b ram_we=%b expected 0 0 0",
               rd_valid, wr_ready, ram_we);
    end
    checks++;
    if (ram_addr !== '0 || rd_data !== '0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_regs: ram_addr=%0d rd_data=%h cmd_ready=%b expected 0 00 1",
               ram_addr, rd_data, cmd_ready);
    end
    // Release with an out-of-range command already waiting.
    @(negedge clk);
    rst_n     = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = ADDR_W'(40);
    cmd_len   = 4'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL first_edge_accept: err=%b expected 1", err);
    end
    @(negedge clk);
  endtask

  task automatic test_err(input int addr);
    do_cmd(1'b1, addr, 3);
    @(negedge clk);
    cmd_valid = 1'b0;
    wr_valid  = 1'b1;
    wr_data   = 8'hEE;
    #1;
    checks++;
    if (err !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0 || ram_we !== 1'b0 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse addr %0d: err=%b cmd_ready=%b busy=%b ram_we=%b wr_ready=%b expected 1 1 0 0 0",
               addr, err, cmd_ready, busy, ram_we, wr_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (err !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL err_end: err=%b ram_we=%b expected 0 0", err, ram_we);
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_reset_mid_read;
    int got = 0;
    int k = 0;
    do_cmd(1'b0, 5, 7);
    rd_ready = 1'b1;
    while (got < 2 && k < 50) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      k++;
      #1;
      if (rd_valid && rd_ready) got++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== ref_mem[7]) begin
      errors++;
      $display("FAIL third_beat: valid=%b data %h expected 1 %h", rd_valid, rd_data, ref_mem[7]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || rd_data !== '0) begin
      errors++;
      $display("FAIL mid_reset: rd_valid=%b busy=%b cmd_ready=%b rd_data=%h expected 0 0 1 00",
               rd_valid, busy, cmd_ready, rd_data);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    rd_ready = 1'b0;
    read_burst(5, 3, 0);
  endtask

  task automatic test_random;
    int addr;
    int len;
    for (int n = 0; n < 8; n++) begin
      addr = $urandom_range(0, DEPTH - 1);
      len  = $urandom_range(0, 15);
      for (int j = 0; j < 16; j++) wbuf[j] = DATA_W'($urandom);
      write_burst(addr, len, 1);
      read_burst(addr, len, 2);
      read_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, 15), 2);
    end
    test_err($urandom_range(DEPTH, (1 << ADDR_W) - 1));
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DATA_W'(i * 7 + 3);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DATA_W'(i * 7 + 3);

    test_reset;

    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    write_burst(5, 3, 0);
    read_burst(5, 3, 0);

    wbuf[0] = 8'hA0; wbuf[1] = 8'hA1; wbuf[2] = 8'hA2; wbuf[3] = 8'hA3;
    write_burst(30, 3, 0);
    read_burst(30, 3, 0);

    read_burst(5, 7, 1);
    test_err(40);
    read_burst(5, 3, 0);
    test_reset_mid_read;
    test_random;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_spram_burst_ctrl
